// File: rtl/i2c_master_arbiter_pkg.sv
// Shared constants and FSM encoding for the I2C master arbiter.
// The 7-bit address width matches the Master instance.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_COMPLETE  = 3'd3,
    S_RECOVER   = 3'd4,
    S_GAP       = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle for the requester side and the shared I2C Master command side.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface i2c_master_arbiter_if
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;

  logic                      m_send;
  logic                      m_r_w;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_data;
  logic                      m_rst;
  logic                      m_tx_done;
  logic                      m_rx_done;
  logic [DATA_W-1:0]         m_data_out;

  modport master (
    input  req, req_rw, req_addr, req_wdata,
    input  m_tx_done, m_rx_done, m_data_out,
    output grant, done, err, rdata,
    output m_send, m_r_w, m_addr, m_data, m_rst
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata,
    output m_tx_done, m_rx_done, m_data_out,
    input  grant, done, err, rdata,
    input  m_send, m_r_w, m_addr, m_data, m_rst
  );

endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// One-hot round-robin picker: first set request searching upward, with wrap,
// starting just after the previous winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    w_found   = 1'b0;
    w_cand    = last;
    grant_idx = last;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(last) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        grant_idx = w_cand;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_onehot[gi] = w_found && (grant_idx == IW'(gi));
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C Master among NUM_REQ requesters: one single-byte transfer per
// grant, completion on the tx_done rising edge, master reset on timeout.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDLE_GAP       = 16,
  parameter int RST_CYCLES     = 2
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.master bus
);

  localparam int IW       = $clog2(NUM_REQ);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AMAX     = (IDLE_GAP > RST_CYCLES) ? IDLE_GAP : RST_CYCLES;
  localparam int AW       = $clog2(AMAX + 1);
  // The IDLE cycle that follows GAP completes the quiet window.
  localparam int GAP_LAST = (IDLE_GAP > 1) ? IDLE_GAP - 2 : 0;
  localparam int RST_LAST = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       w_pick_idx;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   w_rdata;
  logic [TW-1:0]       r_to_cnt;
  logic [AW-1:0]       r_aux_cnt;
  logic [AW-1:0]       r_prst_cnt;
  logic                r_tx_q;
  logic                r_tx_rise;
  logic                w_any_req;
  logic                w_timeout;
  logic                w_finish;
  logic                w_abort;

  logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fields
    assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req          (bus.req),
    .last         (r_last),
    .grant_onehot (w_pick_onehot),
    .grant_idx    (w_pick_idx)
  );

  assign w_any_req = |bus.req;
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_GAP;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any_req) w_state_next = S_LAUNCH;
      S_LAUNCH:    w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (r_tx_rise)      w_state_next = S_COMPLETE;
        else if (w_timeout) w_state_next = S_RECOVER;
      end
      S_COMPLETE:  w_state_next = S_GAP;
      S_RECOVER:   if (r_aux_cnt == AW'(RST_LAST)) w_state_next = S_GAP;
      S_GAP:       if (r_aux_cnt == AW'(GAP_LAST)) w_state_next = S_IDLE;
      default:     w_state_next = S_GAP;
    endcase
  end

  always_comb begin
    w_finish       = (r_state == S_COMPLETE) || w_abort;
    w_abort        = (r_state == S_RECOVER) && (r_aux_cnt == '0);
    w_rdata        = ((r_state == S_COMPLETE) && (r_rw == RW_READ)) ? bus.m_data_out : r_rdata;
    bus.grant      = r_grant;
    bus.done       = w_finish ? r_grant : '0;
    bus.err        = w_abort ? r_grant : '0;
    bus.rdata      = w_rdata;
    bus.m_send     = (r_state == S_LAUNCH);
    bus.m_r_w      = r_rw;
    bus.m_addr     = r_addr;
    bus.m_data     = r_wdata;
    bus.m_rst      = (r_state == S_RECOVER) || (r_prst_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= IW'(NUM_REQ - 1);
      r_grant    <= '0;
      r_rw       <= RW_WRITE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_to_cnt   <= '0;
      r_aux_cnt  <= '0;
      r_prst_cnt <= AW'(RST_CYCLES);
      r_tx_q     <= 1'b0;
      r_tx_rise  <= 1'b0;
    end else begin
      r_rdata   <= w_rdata;
      r_tx_q    <= bus.m_tx_done;
      r_tx_rise <= bus.m_tx_done & ~r_tx_q;
      if (r_prst_cnt != '0) r_prst_cnt <= r_prst_cnt - 1'b1;
      // Restarts on every state change so RECOVER and GAP both count from zero.
      r_aux_cnt <= (w_state_next != r_state) ? '0 : r_aux_cnt + 1'b1;

      if (r_state == S_LAUNCH)         r_to_cnt <= '0;
      else if (r_state == S_WAIT_DONE) r_to_cnt <= r_to_cnt + 1'b1;

      if ((r_state == S_IDLE) && w_any_req) begin
        r_grant <= w_pick_onehot;
        r_last  <= w_pick_idx;
        r_rw    <= bus.req_rw[w_pick_idx];
        r_addr  <= w_addr_arr[w_pick_idx];
        r_wdata <= w_wdata_arr[w_pick_idx];
      end else if (w_state_next == S_GAP) begin
        r_grant <= '0;
      end
    end
  end

  // rx_done is only meaningful while a read command is latched.
  a_rx_only_on_read: assert property (@(posedge clk) disable iff (rst)
    bus.m_rx_done |-> (r_rw == RW_READ));

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: write, read, round-robin order,
// timeout abort with master reset, reset mid-transfer and issue spacing.
module tb_i2c_master_arbiter;
  import i2c_pkg::*;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int IDLE_GAP       = 16;
  localparam int RST_CYCLES     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   stray_done = 0;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .IDLE_GAP       (IDLE_GAP),
    .RST_CYCLES     (RST_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic rw, input logic [6:0] addr, input logic [7:0] wd);
    bus.req_rw[idx]             = rw;
    bus.req_addr[idx*7 +: 7]    = addr;
    bus.req_wdata[idx*8 +: 8]   = wd;
    bus.req[idx]                = 1'b1;
  endtask

  task automatic wait_send(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus.m_send) seen = 1'b1;
      else if (bus.done != '0) stray_done++;
    end
  endtask

  initial begin
    bit  seen;
    bit  got;
    int  lat;
    int  prev_cyc;
    logic [NUM_REQ-1:0] prev_grant;
    logic [NUM_REQ-1:0] exp_grant;

    bus.req        = '0;
    bus.req_rw     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.m_tx_done  = 1'b0;
    bus.m_rx_done  = 1'b0;
    bus.m_data_out = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_grant",  bus.grant,  0);
    chk("rst_done",   bus.done,   0);
    chk("rst_err",    bus.err,    0);
    chk("rst_send",   bus.m_send, 0);
    chk("rst_addr",   bus.m_addr, 0);
    chk("rst_data",   bus.m_data, 0);
    chk("rst_rw",     bus.m_r_w,  0);
    chk("rst_rdata",  bus.rdata,  0);
    rst = 1'b0;
    @(negedge clk);
    chk("prst_hi", bus.m_rst, 1);
    @(negedge clk);
    chk("prst_lo", bus.m_rst, 0);
    repeat (20) @(negedge clk);

    // Single write from requester 0
    bus.m_data_out = 8'h77;
    set_req(0, RW_WRITE, 7'h50, 8'hA5);
    @(negedge clk);
    chk("wr_grant", bus.grant,  4'b0001);
    chk("wr_send",  bus.m_send, 1);
    chk("wr_addr",  bus.m_addr, 7'h50);
    chk("wr_data",  bus.m_data, 8'hA5);
    chk("wr_rw",    bus.m_r_w,  0);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("wr_send_1cyc", bus.m_send, 0);
    bus.m_tx_done = 1'b1;
    @(negedge clk);
    bus.m_tx_done = 1'b0;
    chk("wr_done_early", bus.done, 0);
    @(negedge clk);
    chk("wr_done",  bus.done,  4'b0001);
    chk("wr_err",   bus.err,   0);
    chk("wr_rdata_hold", bus.rdata, 8'h00);
    @(negedge clk);
    chk("wr_gap_grant", bus.grant, 0);
    chk("wr_done_pulse", bus.done, 0);

    // Read from requester 2
    set_req(2, RW_READ, 7'h3C, 8'h00);
    wait_send(40, seen);
    chk("rd_send_seen", seen, 1);
    chk("rd_grant", bus.grant,  4'b0100);
    chk("rd_addr",  bus.m_addr, 7'h3C);
    chk("rd_rw",    bus.m_r_w,  1);
    bus.req[2] = 1'b0;
    @(negedge clk);
    bus.m_tx_done  = 1'b1;
    bus.m_rx_done  = 1'b1;
    bus.m_data_out = 8'h96;
    @(negedge clk);
    bus.m_tx_done = 1'b0;
    bus.m_rx_done = 1'b0;
    chk("rd_rw_stable", bus.m_r_w, 1);
    @(negedge clk);
    chk("rd_done",  bus.done,  4'b0100);
    chk("rd_rdata", bus.rdata, 8'h96);
    chk("rd_rw_at_done", bus.m_r_w, 1);
    @(negedge clk);
    chk("rd_rdata_hold", bus.rdata, 8'h96);

    // Hang abort on requester 1
    set_req(1, RW_WRITE, 7'h22, 8'h0F);
    wait_send(40, seen);
    chk("hang_send_seen", seen, 1);
    chk("hang_grant", bus.grant, 4'b0010);
    bus.req[1] = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= TIMEOUT_CYCLES + 20 && !got; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("hang_latency", lat, TIMEOUT_CYCLES + 1);
    chk("hang_done", bus.done, 4'b0010);
    chk("hang_err",  bus.err,  4'b0010);
    chk("hang_mrst1", bus.m_rst, 1);
    @(negedge clk);
    chk("hang_mrst2", bus.m_rst, 1);
    chk("hang_err_pulse", bus.err, 0);
    @(negedge clk);
    chk("hang_mrst_off", bus.m_rst, 0);

    // Normal service after the abort
    bus.m_data_out = 8'h33;
    set_req(3, RW_WRITE, 7'h11, 8'h5A);
    wait_send(40, seen);
    chk("post_send_seen", seen, 1);
    chk("post_grant", bus.grant,  4'b1000);
    chk("post_addr",  bus.m_addr, 7'h11);
    chk("post_data",  bus.m_data, 8'h5A);
    bus.req[3]    = 1'b0;
    bus.m_tx_done = 1'b1;
    @(negedge clk);
    bus.m_tx_done = 1'b0;
    @(negedge clk);
    chk("post_done",  bus.done,  4'b1000);
    chk("post_err",   bus.err,   0);
    chk("post_rdata", bus.rdata, 8'h96);

    // Reset in the middle of WAIT_DONE
    set_req(2, RW_READ, 7'h40, 8'h00);
    wait_send(40, seen);
    chk("mid_send_seen", seen, 1);
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clk);
    stray_done = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_grant", bus.grant,  0);
    chk("mid_done",  bus.done,   0);
    chk("mid_err",   bus.err,    0);
    chk("mid_send",  bus.m_send, 0);
    chk("mid_rw",    bus.m_r_w,  0);
    chk("mid_addr",  bus.m_addr, 0);
    chk("mid_data",  bus.m_data, 0);
    chk("mid_rdata", bus.rdata,  0);
    chk("mid_mrst",  bus.m_rst,  1);
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, RW_WRITE, 7'(8'h10 + i), 8'(i));
    rst = 1'b0;

    // Fairness and issue spacing with all requests held
    prev_cyc   = 0;
    prev_grant = '0;
    for (int i = 0; i < 6; i++) begin
      exp_grant = NUM_REQ'(1) << (i % NUM_REQ);
      wait_send(60, seen);
      chk("rr_send_seen", seen, 1);
      chk("rr_grant", bus.grant, exp_grant);
      if (i > 0) begin
        chk("rr_spacing", cyc - prev_cyc, IDLE_GAP + 3);
        chk("rr_not_repeat", bus.grant != prev_grant, 1);
      end
      prev_cyc      = cyc;
      prev_grant    = bus.grant;
      bus.m_tx_done = 1'b1;
      @(negedge clk);
      bus.m_tx_done = 1'b0;
      @(negedge clk);
      chk("rr_done", bus.done, exp_grant);
    end
    chk("stray_done", stray_done, 0);

    bus.req = '0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
